tx_symbol_scheduler: RTL and testbench

Sequences the symbol stream into the TX 8b/10b encoder. It merges link-layer packet bytes with periodic SKP ordered sets (two K28.1 symbols each) and idle fill. One symbol is presented to the encoder per enabled cycle. SKP sets are inserted only at packet boundaries, with a bounded pending-SKP credit, so clock-compensation requirements hold without splitting packets.

---
 rtl/tx_symbol_scheduler_if.sv | 23 ++
 rtl/tx_symbol_scheduler.sv | 152 +++++++++++++++
 tb/tb_tx_symbol_scheduler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_symbol_scheduler_if.sv
// Upstream byte stream and encoder symbol bus for the TX symbol scheduler.
interface tx_symbol_scheduler_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_k;
   logic       s_last;
   logic       s_ready;
   logic       enc_valid;
   logic [7:0] enc_din;
   logic       enc_k;

   // link-layer side: drives bytes, observes ready and the encoder stream
   modport master (
      output s_valid, s_data, s_k, s_last,
      input  s_ready, enc_valid, enc_din, enc_k
   );

   // scheduler side
   modport slave (
      input  s_valid, s_data, s_k, s_last,
      output s_ready, enc_valid, enc_din, enc_k
   );
endinterface

// File: rtl/tx_symbol_scheduler.sv
// TX symbol scheduler: merges packet bytes, SKP ordered sets (2x K28.1) and
// idle fill into one symbol per enabled cycle. SKP credits accrue on a symbol
// interval and are spent only between packets.
module tx_symbol_scheduler #(
   parameter int         SKP_INTERVAL = 354,
   parameter int         MAX_PEND     = 4,
   parameter logic [7:0] IDLE_BYTE    = 8'h00,
   parameter logic [7:0] SKP_BYTE     = 8'h3C
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tx_en,
   tx_symbol_scheduler_if.slave  bus,
   output logic [2:0]            skp_pending,
   output logic                  underrun,
   output logic                  skp_overflow
);

   typedef enum logic [1:0] {S_IDLE, S_PKT, S_SKP} state_t;

   // Grant fires on the emission that brings the count to SKP_INTERVAL-1.
   localparam logic [11:0] WRAP_AT  = 12'(SKP_INTERVAL - 2);
   localparam logic [2:0]  PEND_MAX = 3'(MAX_PEND);

   state_t      state, state_nxt;
   logic        in_pkt, in_pkt_nxt;
   logic [11:0] cnt, cnt_nxt;
   logic        skp_idx, skp_idx_nxt;
   logic [2:0]  pend_nxt;
   logic [7:0]  sym_din;
   logic        sym_k;
   logic        non_skp, grant, dec, ufl, ovf;
   logic        accept;

   assign bus.s_ready = tx_en && (state != S_SKP) && !((skp_pending != 3'd0) && !in_pkt);
   assign accept      = bus.s_valid && bus.s_ready;

   // Next-state, symbol select, interval counter and credit bookkeeping.
   always_comb begin
      state_nxt   = state;
      in_pkt_nxt  = in_pkt;
      cnt_nxt     = cnt;
      skp_idx_nxt = skp_idx;
      pend_nxt    = skp_pending;
      sym_din     = IDLE_BYTE;
      sym_k       = 1'b0;
      non_skp     = 1'b0;
      grant       = 1'b0;
      dec         = 1'b0;
      ufl         = 1'b0;
      ovf         = 1'b0;

      if (tx_en) begin
         case (state)
            S_IDLE: begin
               if (skp_pending != 3'd0) begin
                  // first symbol of a set goes out now; S_SKP sends the second
                  sym_din     = SKP_BYTE;
                  sym_k       = 1'b1;
                  skp_idx_nxt = 1'b1;
                  state_nxt   = S_SKP;
               end else begin
                  non_skp = 1'b1;
                  if (accept) begin
                     sym_din = bus.s_data;
                     sym_k   = bus.s_k;
                     if (!bus.s_last) begin
                        state_nxt  = S_PKT;
                        in_pkt_nxt = 1'b1;
                     end
                  end
               end
            end
            S_PKT: begin
               non_skp = 1'b1;
               if (accept) begin
                  sym_din = bus.s_data;
                  sym_k   = bus.s_k;
                  if (bus.s_last) begin
                     state_nxt  = S_IDLE;
                     in_pkt_nxt = 1'b0;
                  end
               end else begin
                  ufl = 1'b1;
               end
            end
            S_SKP: begin
               sym_din = SKP_BYTE;
               sym_k   = 1'b1;
               if (skp_idx) begin
                  dec         = 1'b1;
                  skp_idx_nxt = 1'b0;
               end else begin
                  skp_idx_nxt = 1'b1;
               end
            end
            default: state_nxt = S_IDLE;
         endcase

         if (non_skp) begin
            if (cnt == WRAP_AT) begin
               cnt_nxt = 12'd0;
               grant   = 1'b1;
            end else begin
               cnt_nxt = cnt + 12'd1;
            end
         end

         if (grant && !dec) begin
            if (skp_pending == PEND_MAX) ovf = 1'b1;
            else                         pend_nxt = skp_pending + 3'd1;
         end else if (dec && !grant) begin
            pend_nxt = skp_pending - 3'd1;
         end

         // after the second symbol of a set, chain another set or go idle
         if (dec && (pend_nxt == 3'd0)) state_nxt = S_IDLE;
      end
   end

   // State and registered encoder outputs; tx_en low freezes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         in_pkt        <= 1'b0;
         cnt           <= 12'd0;
         skp_idx       <= 1'b0;
         skp_pending   <= 3'd0;
         bus.enc_valid <= 1'b0;
         bus.enc_din   <= 8'd0;
         bus.enc_k     <= 1'b0;
         underrun      <= 1'b0;
         skp_overflow  <= 1'b0;
      end else if (tx_en) begin
         state         <= state_nxt;
         in_pkt        <= in_pkt_nxt;
         cnt           <= cnt_nxt;
         skp_idx       <= skp_idx_nxt;
         skp_pending   <= pend_nxt;
         bus.enc_valid <= 1'b1;
         bus.enc_din   <= sym_din;
         bus.enc_k     <= sym_k;
         underrun      <= ufl;
         skp_overflow  <= ovf;
      end else begin
         bus.enc_valid <= 1'b0;
         underrun      <= 1'b0;
         skp_overflow  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed bench for tx_symbol_scheduler (SKP_INTERVAL=8, MAX_PEND=4).
module tb_tx_symbol_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_en;
   logic [2:0] skp_pending;
   logic       underrun;
   logic       skp_overflow;

   int n_chk  = 0;
   int n_fail = 0;

   tx_symbol_scheduler_if bus ();

   tx_symbol_scheduler #(
      .SKP_INTERVAL (8),
      .MAX_PEND     (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_en        (tx_en),
      .bus          (bus),
      .skp_pending  (skp_pending),
      .underrun     (underrun),
      .skp_overflow (skp_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_sym(input string tag, input logic [7:0] d, input logic k);
      chk({tag, ".valid"}, 32'(bus.enc_valid), 32'd1);
      chk({tag, ".din"},   32'(bus.enc_din),   32'(d));
      chk({tag, ".k"},     32'(bus.enc_k),     32'(k));
   endtask

   task automatic set_in(input logic v, input logic [7:0] d, input logic last);
      bus.s_valid = v;
      bus.s_data  = d;
      bus.s_k     = 1'b0;
      bus.s_last  = last;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tx_en = 1'b0;
      set_in(1'b0, 8'h00, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tx_en = 1'b1;
      #1;
   endtask

   initial begin
      int e;
      rst_n = 1'b0;
      tx_en = 1'b0;
      set_in(1'b0, 8'h00, 1'b0);
      #2;
      // reset state
      chk("rst.valid",    32'(bus.enc_valid), 32'd0);
      chk("rst.din",      32'(bus.enc_din),   32'd0);
      chk("rst.k",        32'(bus.enc_k),     32'd0);
      chk("rst.pending",  32'(skp_pending),   32'd0);
      chk("rst.underrun", 32'(underrun),      32'd0);
      chk("rst.overflow", 32'(skp_overflow),  32'd0);

      // idle fill until the first credit, then one SKP set
      do_reset();
      chk("idle.ready", 32'(bus.s_ready), 32'd1);
      for (int i = 0; i < 7; i++) begin
         cyc();
         exp_sym("idle.fill", 8'h00, 1'b0);
      end
      chk("idle.pend1", 32'(skp_pending), 32'd1);
      chk("idle.ready0", 32'(bus.s_ready), 32'd0);
      cyc(); exp_sym("idle.skp0", 8'h3C, 1'b1);
      cyc(); exp_sym("idle.skp1", 8'h3C, 1'b1);
      chk("idle.pend0", 32'(skp_pending), 32'd0);
      cyc(); exp_sym("idle.after", 8'h00, 1'b0);

      // 20-byte packet: contiguous, credits held until s_last
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         set_in(1'b1, 8'(i), i == 20);
         #1;
         chk("pkt20.ready", 32'(bus.s_ready), 32'd1);
         cyc();
         exp_sym("pkt20.byte", 8'(i), 1'b0);
         chk("pkt20.pend", 32'(skp_pending), 32'(i / 7));
      end
      set_in(1'b0, 8'h00, 1'b0);
      chk("pkt20.pend2", 32'(skp_pending), 32'd2);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         exp_sym("pkt20.skp", 8'h3C, 1'b1);
         chk("pkt20.skppend", 32'(skp_pending), 32'(2 - i / 2));
      end
      cyc(); exp_sym("pkt20.idle", 8'h00, 1'b0);

      // two-cycle upstream gap mid-packet
      do_reset();
      set_in(1'b1, 8'hA1, 1'b0); cyc(); exp_sym("gap.a1", 8'hA1, 1'b0);
      set_in(1'b1, 8'hA2, 1'b0); cyc(); exp_sym("gap.a2", 8'hA2, 1'b0);
      chk("gap.urun0", 32'(underrun), 32'd0);
      set_in(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         exp_sym("gap.fill", 8'h00, 1'b0);
         chk("gap.urun", 32'(underrun), 32'd1);
         chk("gap.inpkt", 32'(dut.in_pkt), 32'd1);
      end
      set_in(1'b1, 8'hA3, 1'b1); cyc(); exp_sym("gap.a3", 8'hA3, 1'b0);
      chk("gap.urun_end", 32'(underrun), 32'd0);
      chk("gap.inpkt_end", 32'(dut.in_pkt), 32'd0);

      // 50-byte packet: credit saturation and overflow pulses
      do_reset();
      e = 0;
      for (int i = 1; i <= 50; i++) begin
         set_in(1'b1, 8'(i), i == 50);
         cyc();
         exp_sym("pkt50.byte", 8'(i), 1'b0);
         chk("pkt50.pend", 32'(skp_pending), 32'((i / 7) > 4 ? 4 : (i / 7)));
         chk("pkt50.ovf", 32'(skp_overflow), 32'(((i % 7) == 0) && ((i / 7) > 4)));
         if (skp_overflow) e++;
      end
      chk("pkt50.novf", 32'(e), 32'd3);
      set_in(1'b0, 8'h00, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         cyc();
         exp_sym("pkt50.skp", 8'h3C, 1'b1);
         chk("pkt50.skppend", 32'(skp_pending), 32'(4 - i / 2));
      end
      cyc(); exp_sym("pkt50.idle", 8'h00, 1'b0);

      // tx_en pause between the two symbols of a SKP set
      do_reset();
      for (int i = 0; i < 7; i++) cyc();
      cyc(); exp_sym("pause.skp0", 8'h3C, 1'b1);
      tx_en = 1'b0;
      set_in(1'b1, 8'h55, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("pause.ready", 32'(bus.s_ready), 32'd0);
         cyc();
         chk("pause.valid", 32'(bus.enc_valid), 32'd0);
      end
      tx_en = 1'b1;
      #1;
      chk("pause.ready_skp", 32'(bus.s_ready), 32'd0);
      cyc(); exp_sym("pause.skp1", 8'h3C, 1'b1);
      chk("pause.pend0", 32'(skp_pending), 32'd0);
      chk("pause.ready1", 32'(bus.s_ready), 32'd1);
      cyc(); exp_sym("pause.byte", 8'h55, 1'b0);
      set_in(1'b0, 8'h00, 1'b0);

      // async reset mid-packet
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         set_in(1'b1, 8'(8'hB0 + i), 1'b0);
         cyc();
      end
      rst_n = 1'b0;
      #1;
      chk("rstpkt.valid", 32'(bus.enc_valid), 32'd0);
      chk("rstpkt.din",   32'(bus.enc_din),   32'd0);
      chk("rstpkt.inpkt", 32'(dut.in_pkt),    32'd0);
      set_in(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rstpkt.ready", 32'(bus.s_ready), 32'd1);
      cyc(); exp_sym("rstpkt.idle", 8'h00, 1'b0);
      chk("rstpkt.urun", 32'(underrun), 32'd0);

      // async reset mid-SKP set: credit discarded, no stale SKP
      do_reset();
      for (int i = 0; i < 7; i++) cyc();
      cyc(); exp_sym("rstskp.skp0", 8'h3C, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rstskp.valid", 32'(bus.enc_valid), 32'd0);
      chk("rstskp.din",   32'(bus.enc_din),   32'd0);
      chk("rstskp.k",     32'(bus.enc_k),     32'd0);
      chk("rstskp.pend",  32'(skp_pending),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rstskp.ready", 32'(bus.s_ready), 32'd1);
      cyc(); exp_sym("rstskp.idle", 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
